id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the dynamic-pipeline MIPS core.
- Sits directly downstream of the register file: it consumes the rs/rt read data and the decoded ID-stage fields.
- Applies EX/MEM operand forwarding, detects load-use hazards and generates stall_id for IF/ID.
- Presents registered, hazard-resolved operands to the EX stage.

Parameters:
CTRL_W, 16, width of the opaque EX/MEM/WB control bundle carried through unchanged
CNT_W, 16, width of the saturating load-use stall performance counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
ena  in  1  stage enable; low = hold all state, stall_id=0
id_valid  in  1  ID slot holds a real instruction
id_rsc  in  5  rs register number (also drives regfile rsc)
id_rtc  in  5  rt register number
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_dest  in  5  destination register number
id_rf_w  in  1  instruction writes the regfile
id_mem_rd  in  1  instruction is a load
id_ctrl  in  CTRL_W  decoded control bundle
id_imm  in  32  extended immediate
rf_rs  in  32  regfile rs read data
rf_rt  in  32  regfile rt read data
ex_result  in  32  ALU result of the instruction currently in EX
mem_valid  in  1  MEM slot valid
mem_dest  in  5  MEM destination register
mem_rf_w  in  1  MEM instruction writes the regfile
mem_result  in  32  MEM writeback value (load data already merged)
ex_busy  in  1  EX is multi-cycle busy; hold this register
flush  in  1  branch/jump redirect; kill ID and EX slots
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  registered: EX slot valid
ex_rs  out  32  registered forwarded rs operand
ex_rt  out  32  registered forwarded rt operand
ex_imm  out  32  registered immediate
ex_dest  out  5  registered destination
ex_rf_w  out  1  registered write enable
ex_mem_rd  out  1  registered load flag
ex_ctrl  out  CTRL_W  registered control bundle
lu_stall_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: all registered outputs 0, including lu_stall_cnt. Asynchronous, takes priority over everything else.
- Regfile writes on the falling edge, so a WB-stage write is already visible in rf_rs/rf_rt during the same cycle. No WB forwarding path exists.
- Operand source match rules. A stage "matches" rs when all of the following hold: that stage is valid, its write enable is set, its destination is non-zero, its destination equals id_rsc, and id_use_rs is set. The rt match is the same using id_rtc and id_use_rt.
- Operand selection (combinational), priority high to low:
  - EX match with ex_mem_rd=0 -> ex_result.
  - MEM match -> mem_result.
  - Otherwise -> rf_rs / rf_rt.
- Register 0 never forwards and never stalls.
- load_use = id_valid & EX match on rs or rt & ex_mem_rd=1.
- stall_id = ena & ~flush & (ex_busy | load_use).
- Posedge update when ena=1, priority high to low:
  1. flush: ex_valid<=0, ex_rf_w<=0, ex_mem_rd<=0. Other fields are don't-care. Overrides ex_busy.
  2. ex_busy: hold every register. No bubble, no count.
  3. load_use: insert a bubble (ex_valid, ex_rf_w, ex_mem_rd <= 0). lu_stall_cnt increments, saturating at all-ones.
  4. Otherwise: capture the forwarded operands and all id_* fields. ex_valid <= id_valid.
- Load-use latency: exactly 1 bubble. On the following cycle the load sits in MEM and its data is forwarded through the MEM path.
- When id_valid=0, no stall is raised and ex_valid captures 0.
- ena=0: registers and counter hold; stall_id=0.
- Reset asserted mid-stall clears everything; after release the first edge captures normally.

Test Plan:
- Reset: assert rst with clk running -> all outputs 0, stall_id=0; release, id_valid=1, rf_rs=0x11 -> next edge ex_rs=0x11, ex_valid=1.
- EX forward: EX holds add $3 (ex_result=0xA5A5), next instruction reads $3, MEM also dest $3 with mem_result=0x1234 -> ex_rs=0xA5A5 (EX wins).
- Load-use: lw $5 in EX, next instruction uses rt=$5 -> stall_id=1 for 1 cycle, bubble (ex_valid=0), lu_stall_cnt=1. Next edge with mem_dest=5, mem_result=0xDEAD -> ex_rt=0xDEAD, stall_id=0.
- r0: EX dest=0 with rf_w=1, ex_mem_rd=1, instruction reads $0 -> no stall, operand = rf value 0.
- flush with ex_busy=1 and load_use=1 simultaneously -> stall_id=0, ex_valid=0 next edge, counter unchanged.
- ena=0 for 3 cycles with changing id_* inputs -> outputs and counter hold; counter saturates after 2^CNT_W−1 forced load-use bubbles.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX/MEM operand forwarding,
// load-use bubble insertion and a saturating load-use stall counter.
module id_ex_operand_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              id_valid,
  input  logic [4:0]        id_rsc,
  input  logic [4:0]        id_rtc,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [4:0]        id_dest,
  input  logic              id_rf_w,
  input  logic              id_mem_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_imm,
  input  logic [31:0]       rf_rs,
  input  logic [31:0]       rf_rt,
  input  logic [31:0]       ex_result,
  input  logic              mem_valid,
  input  logic [4:0]        mem_dest,
  input  logic              mem_rf_w,
  input  logic [31:0]       mem_result,
  input  logic              ex_busy,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [31:0]       ex_rs,
  output logic [31:0]       ex_rt,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_dest,
  output logic              ex_rf_w,
  output logic              ex_mem_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  lu_stall_cnt
);
  logic              r_valid, r_rf_w, r_mem_rd;
  logic [31:0]       r_rs, r_rt, r_imm;
  logic [4:0]        r_dest;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_load_use;
  logic [31:0]       w_fwd_rs, w_fwd_rt;
  // A zero destination never matches, so $0 neither forwards nor stalls.
  assign w_ex_rs  = r_valid & r_rf_w & (r_dest != 5'd0) & (r_dest == id_rsc) & id_use_rs;
  assign w_ex_rt  = r_valid & r_rf_w & (r_dest != 5'd0) & (r_dest == id_rtc) & id_use_rt;
  assign w_mem_rs = mem_valid & mem_rf_w & (mem_dest != 5'd0) & (mem_dest == id_rsc) & id_use_rs;
  assign w_mem_rt = mem_valid & mem_rf_w & (mem_dest != 5'd0) & (mem_dest == id_rtc) & id_use_rt;
  assign w_fwd_rs = (w_ex_rs & ~r_mem_rd) ? ex_result : w_mem_rs ? mem_result : rf_rs;
  assign w_fwd_rt = (w_ex_rt & ~r_mem_rd) ? ex_result : w_mem_rt ? mem_result : rf_rt;
  assign w_load_use = id_valid & (w_ex_rs | w_ex_rt) & r_mem_rd;
  assign stall_id   = ena & ~flush & (ex_busy | w_load_use);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_rf_w   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_imm    <= '0;
      r_dest   <= '0;
      r_ctrl   <= '0;
      r_cnt    <= '0;
    end else if (ena) begin
      if (flush) begin
        r_valid  <= 1'b0;
        r_rf_w   <= 1'b0;
        r_mem_rd <= 1'b0;
      end else if (!ex_busy && w_load_use) begin
        r_valid  <= 1'b0;
        r_rf_w   <= 1'b0;
        r_mem_rd <= 1'b0;
        r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      end else if (!ex_busy) begin
        r_valid  <= id_valid;
        r_rf_w   <= id_rf_w;
        r_mem_rd <= id_mem_rd;
        r_rs     <= w_fwd_rs;
        r_rt     <= w_fwd_rt;
        r_imm    <= id_imm;
        r_dest   <= id_dest;
        r_ctrl   <= id_ctrl;
      end
    end
  end
  assign ex_valid     = r_valid;
  assign ex_rf_w      = r_rf_w;
  assign ex_mem_rd    = r_mem_rd;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_imm       = r_imm;
  assign ex_dest      = r_dest;
  assign ex_ctrl      = r_ctrl;
  assign lu_stall_cnt = r_cnt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage
// against a behavioural model of the EX slot contents.
module tb_id_ex_operand_stage;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  logic clk = 1'b0, rst = 1'b0, ena;
  logic id_valid, id_use_rs, id_use_rt, id_rf_w, id_mem_rd;
  logic [4:0] id_rsc, id_rtc, id_dest, mem_dest;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0] id_imm, rf_rs, rf_rt, ex_result, mem_result;
  logic mem_valid, mem_rf_w, ex_busy, flush;
  logic stall_id, ex_valid, ex_rf_w, ex_mem_rd;
  logic [31:0] ex_rs, ex_rt, ex_imm;
  logic [4:0] ex_dest;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0] lu_stall_cnt;
  int checks = 0, errors = 0;

  id_ex_operand_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .id_valid(id_valid), .id_rsc(id_rsc), .id_rtc(id_rtc),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_rf_w(id_rf_w),
    .id_mem_rd(id_mem_rd), .id_ctrl(id_ctrl), .id_imm(id_imm), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .ex_result(ex_result), .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_rf_w(mem_rf_w),
    .mem_result(mem_result), .ex_busy(ex_busy), .flush(flush), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_rf_w(ex_rf_w), .ex_mem_rd(ex_mem_rd), .ex_ctrl(ex_ctrl), .lu_stall_cnt(lu_stall_cnt));

  always #5 clk = ~clk;

  // Model of what the EX slot should hold; m_known is false after a flush or bubble,
  // when the data fields carry no defined value.
  logic m_valid, m_rf_w, m_mem_rd, m_known;
  logic [4:0] m_dest;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [CTRL_W-1:0] m_ctrl;
  int m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_ex(input logic [4:0] r, input logic u);
    return u && r != 0 && m_valid && m_rf_w && m_dest == r;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic u, input logic [31:0] rf);
    if (in_ex(r, u) && !m_mem_rd) return ex_result;
    if (u && r != 0 && mem_valid && mem_rf_w && mem_dest == r) return mem_result;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rf_w = 0; m_mem_rd = 0; m_known = 1;
    m_dest = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  task automatic chk_outputs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_rf_w", ex_rf_w, m_rf_w);
    chk("ex_mem_rd", ex_mem_rd, m_mem_rd);
    chk("lu_stall_cnt", lu_stall_cnt, m_cnt);
    if (m_known) begin
      chk("ex_rs", ex_rs, m_rs);
      chk("ex_rt", ex_rt, m_rt);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_dest", ex_dest, m_dest);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
    end
  endtask

  // Called at a negedge with inputs already driven; returns after the next negedge.
  task automatic cycle();
    bit lu;
    logic [31:0] nrs, nrt;
    #1;
    lu = id_valid && m_mem_rd && (in_ex(id_rsc, id_use_rs) || in_ex(id_rtc, id_use_rt));
    chk("stall_id", stall_id, ena && !flush && (ex_busy || lu));
    nrs = operand(id_rsc, id_use_rs, rf_rs);
    nrt = operand(id_rtc, id_use_rt, rf_rt);
    @(posedge clk); #1;
    if (ena) begin
      if (flush) begin
        m_valid = 0; m_rf_w = 0; m_mem_rd = 0; m_known = 0;
      end else if (!ex_busy && lu) begin
        m_valid = 0; m_rf_w = 0; m_mem_rd = 0; m_known = 0;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (!ex_busy) begin
        m_valid = id_valid; m_rf_w = id_rf_w; m_mem_rd = id_mem_rd; m_known = 1;
        m_rs = nrs; m_rt = nrt; m_imm = id_imm; m_dest = id_dest; m_ctrl = id_ctrl;
      end
    end
    chk_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    ena = 1; flush = 0; ex_busy = 0;
    id_valid = 0; id_rsc = 0; id_rtc = 0; id_use_rs = 0; id_use_rt = 0;
    id_dest = 0; id_rf_w = 0; id_mem_rd = 0; id_ctrl = 0; id_imm = 0;
    rf_rs = 0; rf_rt = 0; ex_result = 0;
    mem_valid = 0; mem_dest = 0; mem_rf_w = 0; mem_result = 0;
  endtask

  task automatic issue(input logic [4:0] dest, input logic rfw, input logic mrd);
    id_valid = 1; id_dest = dest; id_rf_w = rfw; id_mem_rd = mrd;
    id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
  endtask

  task automatic randomize_inputs();
    ena = ($urandom_range(0, 9) != 0); flush = ($urandom_range(0, 11) == 0);
    ex_busy = ($urandom_range(0, 7) == 0);
    id_valid = ($urandom_range(0, 4) != 0);
    id_rsc = 5'($urandom_range(0, 3)); id_rtc = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    id_dest = 5'($urandom_range(0, 3)); id_rf_w = 1'($urandom); id_mem_rd = ($urandom_range(0, 2) == 0);
    id_ctrl = CTRL_W'($urandom); id_imm = $urandom; rf_rs = $urandom; rf_rt = $urandom;
    ex_result = $urandom; mem_valid = 1'($urandom); mem_dest = 5'($urandom_range(0, 3));
    mem_rf_w = 1'($urandom); mem_result = $urandom;
  endtask

  initial begin
    logic [31:0] snap_rs;
    logic [CNT_W-1:0] snap_cnt;
    idle();
    // Reset with clock running
    rst = 1; model_reset();
    repeat (2) @(negedge clk);
    chk("rst_stall", stall_id, 0);
    chk_outputs();
    rst = 0;
    issue(7, 1, 0); rf_rs = 32'h11; id_rsc = 2; id_use_rs = 1;
    cycle();
    chk("rst_first_rs", ex_rs, 32'h11);
    chk("rst_first_valid", ex_valid, 1);
    // EX forward beats MEM forward
    issue(3, 1, 0); cycle();
    issue(9, 1, 0); id_rsc = 3; id_use_rs = 1; rf_rs = 32'h5555; ex_result = 32'hA5A5;
    mem_valid = 1; mem_dest = 3; mem_rf_w = 1; mem_result = 32'h1234;
    cycle();
    chk("ex_fwd_rs", ex_rs, 32'hA5A5);
    // Load-use: one bubble, then MEM forward
    idle(); issue(5, 1, 1); cycle();
    issue(6, 1, 0); id_rtc = 5; id_use_rt = 1; rf_rt = 32'h7777;
    #1 chk("lu_stall", stall_id, 1);
    cycle();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", lu_stall_cnt, 1);
    mem_valid = 1; mem_dest = 5; mem_rf_w = 1; mem_result = 32'hDEAD;
    #1 chk("lu_release", stall_id, 0);
    cycle();
    chk("lu_mem_fwd", ex_rt, 32'hDEAD);
    chk("lu_valid", ex_valid, 1);
    // $0 never stalls or forwards
    idle(); issue(0, 1, 1); cycle();
    issue(4, 1, 0); id_rsc = 0; id_use_rs = 1; rf_rs = 0; ex_result = 32'hBAD;
    #1 chk("r0_stall", stall_id, 0);
    cycle();
    chk("r0_rs", ex_rs, 0);
    // flush beats busy and load-use
    idle(); issue(8, 1, 1); cycle();
    issue(2, 1, 0); id_rsc = 8; id_use_rs = 1; ex_busy = 1; flush = 1;
    snap_cnt = lu_stall_cnt;
    cycle();
    chk("flush_valid", ex_valid, 0);
    chk("flush_cnt", lu_stall_cnt, snap_cnt);
    // ena low holds everything
    idle(); issue(10, 1, 0); rf_rs = 32'hCAFE; id_use_rs = 1; id_rsc = 1; cycle();
    snap_rs = ex_rs; snap_cnt = lu_stall_cnt;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(); ena = 0; cycle();
    end
    chk("ena_hold_rs", ex_rs, snap_rs);
    chk("ena_hold_cnt", lu_stall_cnt, snap_cnt);
    // Counter saturation
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      idle(); issue(1, 1, 1); cycle();
      issue(2, 1, 0); id_rsc = 1; id_use_rs = 1; cycle();
    end
    chk("cnt_saturated", lu_stall_cnt, (1 << CNT_W) - 1);
    // Reset during a stall, then normal capture
    idle(); issue(6, 1, 1); cycle();
    issue(3, 1, 0); id_rtc = 6; id_use_rt = 1;
    #1 chk("pre_rst_stall", stall_id, 1);
    rst = 1; #1 model_reset();
    chk_outputs();
    @(negedge clk); rst = 0;
    idle(); issue(12, 1, 0); rf_rs = 32'h42; id_rsc = 7; id_use_rs = 1;
    cycle();
    chk("post_rst_rs", ex_rs, 32'h42);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(); cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
